multdiv_unit: RTL

Iterative RV32M multiply/divide execution unit. It consumes the 5-bit `alu_function` codes that the ALU controller emits for M-extension instructions (`funct7[0]` set). The ALU datapath hands it operands and stalls the core on `busy`. It returns a 32-bit result with a one-cycle `done` pulse, and it is the execution-side counterpart of the M-extension decode path.

---
 rtl/multdiv_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to compute all multiplies in a single step instead.
module multdiv_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  alu_function,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic [2:0]  func3;
    logic        accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic        div_zero, div_ovf, special;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [33:0] trial;
    logic [63:0] mul_next, div_next, prod;
    logic [31:0] quo, rem, final_sel;

    assign func3    = alu_function[2:0];
    assign accept   = start && (alu_function[4:3] == 2'b10) && (state_q == IDLE) && !flush;
    assign is_div   = func3[2];
    assign a_signed = (func3 == F_MULH) || (func3 == F_MULHSU) || (func3 == F_DIV) || (func3 == F_REM);
    assign b_signed = (func3 == F_MULH) || (func3 == F_DIV) || (func3 == F_REM);
    assign a_neg    = a_signed && operand_a[31];
    assign b_neg    = b_signed && operand_b[31];
    assign mag_a    = a_neg ? (32'd0 - operand_a) : operand_a;
    assign mag_b    = b_neg ? (32'd0 - operand_b) : operand_b;
    assign div_zero = is_div && (operand_b == 32'd0);
    assign div_ovf  = is_div && !func3[0] && (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
    assign special  = div_zero || div_ovf || !is_div;
`else
    assign special  = div_zero || div_ovf;
`endif

    // The accumulator holds {partial product} for multiplies and {remainder, quotient} for divides.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    assign mul_next  = {mul_sum, acc_q[31:1]};
    assign rem_shift = acc_q[63:31];
    assign trial     = {1'b0, rem_shift} - {2'b00, opb_q};
    assign div_next  = trial[33] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};

    assign prod = neg_res_q ? (64'd0 - acc_q) : acc_q;
    assign quo  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        final_sel = prod[63:32];
        case (op_q)
            F_MUL:           final_sel = prod[31:0];
            F_DIV, F_DIVU:   final_sel = quo;
            F_REM, F_REMU:   final_sel = rem;
            default:         final_sel = prod[63:32];
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? FINISH : CALC;
            CALC: begin
                if (flush)               state_d = IDLE;
                else if (cnt_q == 5'd0)  state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Special cases preload the accumulator with the final answer and clear the sign fixups.
    always_comb begin
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        result_d  = result_q;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = func3;
                    cnt_d     = 5'd31;
                    opa_d     = mag_a;
                    opb_d     = mag_b;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (div_zero) begin
                        acc_d     = {operand_a, 32'hFFFF_FFFF};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else if (div_ovf) begin
                        acc_d     = {32'h0000_0000, 32'h8000_0000};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        acc_d = {32'h0000_0000, mag_a} * {32'h0000_0000, mag_b};
                    end
`endif
                    else begin
                        acc_d = {32'h0000_0000, is_div ? mag_a : mag_b};
                    end
                end
            end
            CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q - 5'd1;
            end
            FINISH: begin
                if (!flush) begin
                    done_d   = 1'b1;
                    result_d = final_sel;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= 3'd0;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
